// File: rtl/inst_encoder_loader_if.sv
// inst_encoder_loader_if: field-bundle input handshake plus imem write port and load status
interface inst_encoder_loader_if #(parameter int ADDR_W = 10);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_fmt;
  logic [6:0]        in_opcode;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [4:0]        in_rd;
  logic [31:0]       in_imm;
  logic              in_last;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   word_count;
  logic              done;
  logic              err;
  modport slave (
    input  in_valid, in_fmt, in_opcode, in_funct3, in_funct7, in_rs1, in_rs2, in_rd, in_imm, in_last,
    output in_ready, imem_we, imem_addr, imem_wdata, word_count, done, err
  );
  modport master (
    output in_valid, in_fmt, in_opcode, in_funct3, in_funct7, in_rs1, in_rs2, in_rd, in_imm, in_last,
    input  in_ready, imem_we, imem_addr, imem_wdata, word_count, done, err
  );
endinterface

// File: rtl/inst_encoder_loader.sv
// inst_encoder_loader: packs RV32I field bundles into words, writes them to imem, appends a halt word
module inst_encoder_loader #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = 1024
) (
  input logic clk,
  input logic rst,
  inst_encoder_loader_if.slave bus
);
  localparam logic [1:0] LOAD = 2'd0;
  localparam logic [1:0] TERM = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_SLOT = ADDR_W'(BASE_ADDR + MAX_WORDS - 1);
  logic [1:0]        state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d, ptr_q, ptr_d;
  logic [31:0]       wdata_q, wdata_d, enc;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              acc, bad;
  always_comb begin
    enc = bus.in_fmt == 3'd0 ? {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode} :
          bus.in_fmt == 3'd1 ? {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode} :
          bus.in_fmt == 3'd2 ? {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_imm[4:0], bus.in_opcode} :
          bus.in_fmt == 3'd3 ? {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                                bus.in_imm[4:1], bus.in_imm[11], bus.in_opcode} :
          bus.in_fmt == 3'd4 ? {bus.in_imm[31:12], bus.in_rd, bus.in_opcode} :
                               {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11], bus.in_imm[19:12], bus.in_rd, bus.in_opcode};
    acc = bus.in_valid && state_q == LOAD;
    // the top slot is kept for the halt word, so any bundle landing there is an overflow
    bad = bus.in_fmt > 3'd5 || ((bus.in_fmt == 3'd3 || bus.in_fmt == 3'd5) && bus.in_imm[0]) || ptr_q == LAST_SLOT;
    state_d = acc ? (bad ? ERR : bus.in_last ? TERM : LOAD) : state_q == TERM ? DONE : state_q;
    we_d    = (acc && !bad) || state_q == TERM;
    addr_d  = we_d ? ptr_q : addr_q;
    ptr_d   = ptr_q + {{(ADDR_W-1){1'b0}}, we_d};
    wdata_d = acc && !bad ? enc : state_q == TERM ? 32'h0 : wdata_q;
    cnt_d   = cnt_q + {{ADDR_W{1'b0}}, we_d};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      we_q    <= 1'b0;
      addr_q  <= BASE;
      ptr_q   <= BASE;
      wdata_q <= 32'h0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      ptr_q   <= ptr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end
  assign bus.in_ready   = state_q == LOAD;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.word_count = cnt_q;
  assign bus.done       = state_q == DONE;
  assign bus.err        = state_q == ERR;
endmodule
